// File: rtl/gpu_text_pkg.sv
// ============================================================================
// Module  : gpu_text_pkg
// Brief   : Shared constants, control codes and FSM encoding for the text console.
// Revision: 1.0
// ============================================================================
`default_nettype none

package gpu_text_pkg;
    localparam int COLS          = 80;
    localparam int ROWS          = 25;
    localparam int WORDS_PER_ROW = COLS / 4;

    localparam logic [31:0] BLANK_WORD = 32'h2020_2020;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;

    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EXEC      = 3'd1,
        ST_SCROLL_RD = 3'd2,
        ST_SCROLL_WR = 3'd3,
        ST_CLEAR     = 3'd4
    } state_t;
endpackage

`default_nettype wire

// File: rtl/gpu_text_cursor.sv
// ============================================================================
// Module  : gpu_text_cursor
// Brief   : Cursor position register, edit operations and byte-to-word/lane map.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gpu_text_cursor #(
    parameter int COLS    = gpu_text_pkg::COLS,
    parameter int ROWS    = gpu_text_pkg::ROWS,
    parameter int VRAM_AW = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_print_i,
    input  logic               op_lf_i,
    input  logic               op_cr_i,
    input  logic               op_bs_i,
    input  logic               op_home_i,
    output logic [6:0]         cur_col_o,
    output logic [4:0]         cur_row_o,
    output logic [VRAM_AW-1:0] word_addr_o,
    output logic [1:0]         lane_o,
    output logic               wrap_o,
    output logic               scroll_req_o
);
    localparam int c_bw = VRAM_AW + 2;

    logic [6:0]      col_q, col_d;
    logic [4:0]      row_q, row_d;
    logic            w_adv_row;
    logic [c_bw-1:0] w_baddr;

    assign w_baddr      = c_bw'(row_q) * c_bw'(COLS) + c_bw'(col_q);
    assign word_addr_o  = w_baddr[c_bw-1:2];
    assign lane_o       = w_baddr[1:0];
    assign wrap_o       = (col_q == 7'(COLS - 1));
    // Cursor sits on the last row: any row advance now must scroll instead.
    assign scroll_req_o = (row_q == 5'(ROWS - 1));
    assign cur_col_o    = col_q;
    assign cur_row_o    = row_q;

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        w_adv_row = 1'b0;
        if (op_home_i) begin
            col_d = '0;
            row_d = '0;
        end else if (op_print_i) begin
            if (wrap_o) begin
                col_d     = '0;
                w_adv_row = 1'b1;
            end else begin
                col_d = col_q + 7'd1;
            end
        end else if (op_lf_i) begin
            col_d     = '0;
            w_adv_row = 1'b1;
        end else if (op_cr_i) begin
            col_d = '0;
        end else if (op_bs_i && (col_q != '0)) begin
            col_d = col_q - 7'd1;
        end
        if (w_adv_row && !scroll_req_o) begin
            row_d = row_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
endmodule

`default_nettype wire

// File: rtl/gpu_text_console.sv
// ============================================================================
// Module  : gpu_text_console
// Brief   : Byte-stream text console writing ASCII into gpu_vram port A, with
//           line wrap, row-copy scrolling and screen clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gpu_text_console #(
    parameter int COLS           = gpu_text_pkg::COLS,
    parameter int ROWS           = gpu_text_pkg::ROWS,
    parameter int VRAM_AW        = 9,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [31:0]        vram_wdata,
    output logic [3:0]         vram_wstrb,
    input  logic [31:0]        vram_rdata,
    output logic [6:0]         cur_col,
    output logic [4:0]         cur_row,
    output logic               busy
);
    import gpu_text_pkg::*;

    localparam int c_row_words    = COLS / 4;
    localparam int c_scroll_words = (ROWS - 1) * c_row_words;
    localparam int c_total_words  = ROWS * c_row_words;

    localparam logic [VRAM_AW:0] c_row_step    = (VRAM_AW+1)'(c_row_words);
    localparam logic [VRAM_AW:0] c_scroll_last = (VRAM_AW+1)'(c_scroll_words - 1);
    localparam logic [VRAM_AW:0] c_clear_last  = (VRAM_AW+1)'(c_total_words - 1);

    state_t             state_q, state_d;
    logic [VRAM_AW:0]   cnt_q, cnt_d;
    logic [7:0]         data_q;

    logic               w_exec, w_printable;
    logic               w_op_print, w_op_lf, w_op_cr, w_op_bs, w_op_home;
    logic [6:0]         w_col;
    logic [4:0]         w_row;
    logic [VRAM_AW-1:0] w_word;
    logic [1:0]         w_lane;
    logic               w_wrap, w_at_bottom, w_scroll;

    assign w_exec      = (state_q == ST_EXEC) && !reset;
    assign w_printable = (data_q >= PRINT_MIN) && (data_q <= PRINT_MAX);
    assign w_op_print  = w_exec && w_printable;
    assign w_op_lf     = w_exec && (data_q == CH_LF);
    assign w_op_cr     = w_exec && (data_q == CH_CR);
    assign w_op_bs     = w_exec && (data_q == CH_BS);
    assign w_op_home   = w_exec && (data_q == CH_FF);
    // A row advance on the last row turns into a scroll.
    assign w_scroll    = w_at_bottom && (w_op_lf || (w_op_print && w_wrap));

    gpu_text_cursor #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .VRAM_AW (VRAM_AW)
    ) u_cursor (
        .clk          (clk),
        .reset        (reset),
        .op_print_i   (w_op_print),
        .op_lf_i      (w_op_lf),
        .op_cr_i      (w_op_cr),
        .op_bs_i      (w_op_bs),
        .op_home_i    (w_op_home),
        .cur_col_o    (w_col),
        .cur_row_o    (w_row),
        .word_addr_o  (w_word),
        .lane_o       (w_lane),
        .wrap_o       (w_wrap),
        .scroll_req_o (w_at_bottom)
    );

    assign cur_col = reset ? 7'd0 : w_col;
    assign cur_row = reset ? 5'd0 : w_row;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_ready   = 1'b0;
        busy       = 1'b0;
        vram_addr  = '0;
        vram_wdata = '0;
        vram_wstrb = '0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (w_op_print) begin
                    vram_addr  = w_word;
                    vram_wdata = {4{data_q}};
                    vram_wstrb = 4'b0001 << w_lane;
                end
                cnt_d = '0;
                if (w_op_home)     state_d = ST_CLEAR;
                else if (w_scroll) state_d = ST_SCROLL_RD;
                else               state_d = ST_IDLE;
            end
            ST_SCROLL_RD: begin
                busy      = 1'b1;
                vram_addr = VRAM_AW'(cnt_q + c_row_step);
                state_d   = ST_SCROLL_WR;
            end
            ST_SCROLL_WR: begin
                busy       = 1'b1;
                vram_addr  = VRAM_AW'(cnt_q);
                vram_wdata = vram_rdata;
                vram_wstrb = 4'hF;
                cnt_d      = cnt_q + 1'b1;
                // The counter carries straight on into the last-row blanking.
                state_d    = (cnt_q == c_scroll_last) ? ST_CLEAR : ST_SCROLL_RD;
            end
            ST_CLEAR: begin
                busy       = 1'b1;
                vram_addr  = VRAM_AW'(cnt_q);
                vram_wdata = BLANK_WORD;
                vram_wstrb = 4'hF;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == c_clear_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset) begin
            in_ready   = 1'b0;
            busy       = 1'b0;
            vram_addr  = '0;
            vram_wdata = '0;
            vram_wstrb = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q == ST_IDLE) && in_valid) data_q <= in_data;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_gpu_text_console.sv
// ============================================================================
// Module  : tb_gpu_text_console
// Brief   : Self-checking bench for gpu_text_console with a port-A VRAM model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gpu_text_console;
    localparam logic [31:0] BLANK = 32'h2020_2020;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  vram_addr;
    logic [31:0] vram_wdata;
    logic [3:0]  vram_wstrb;
    logic [31:0] vram_rdata;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;

    logic [31:0] mem [0:511];
    logic [1:0]  fill_sel;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  d;
        logic        wr;
        logic [8:0]  a;
        logic [31:0] w;
        logic [3:0]  s;
        logic [6:0]  col;
        logic [4:0]  row;
    } vec_t;
    vec_t vecs [16];

    gpu_text_console #(
        .COLS           (80),
        .ROWS           (25),
        .VRAM_AW        (9),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_wstrb (vram_wstrb),
        .vram_rdata (vram_rdata),
        .cur_col    (cur_col),
        .cur_row    (cur_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // VRAM port A: byte-strobed write, registered read; backdoor fills for setup.
    always @(posedge clk) begin
        if (fill_sel == 2'd1) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'hDEAD_BEEF;
        end else if (fill_sel == 2'd2) begin
            for (int i = 0; i < 512; i++) mem[i] <= pat(i);
        end else begin
            for (int k = 0; k < 4; k++)
                if (vram_wstrb[k]) mem[vram_addr][8*k +: 8] <= vram_wdata[8*k +: 8];
        end
        vram_rdata <= mem[vram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_blank(input string nm, input int lo, input int hi);
        int bad = 0;
        for (int i = lo; i <= hi; i++) if (mem[i] !== BLANK) bad++;
        chk(nm, 32'(bad), 32'd0);
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 3000) begin
            n++;
            @(negedge clk); #1;
        end
    endtask

    // Called between a negedge and the next posedge; returns the same way,
    // one cycle after EXEC, with the EXEC-cycle write outputs captured.
    task automatic send(input logic [7:0] d, output logic [3:0] s,
                        output logic [8:0] a, output logic [31:0] w);
        int n = 0;
        while (!in_ready && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: in_ready got 0, want 1");
        end
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk); #1;
        in_valid = 1'b0;
        s = vram_wstrb;
        a = vram_addr;
        w = vram_wdata;
        @(negedge clk); #1;
    endtask

    initial begin
        logic [3:0]  s;
        logic [8:0]  a;
        logic [31:0] w;
        int          n, n_rdy, n_wr, bad_wr, exp_addr, bad;

        vecs[0]  = '{8'h41, 1'b1, 9'd0,  32'h4141_4141, 4'h1, 7'd1, 5'd0};
        vecs[1]  = '{8'h0A, 1'b0, 9'd0,  32'h0,         4'h0, 7'd0, 5'd1};
        vecs[2]  = '{8'h30, 1'b1, 9'd20, 32'h3030_3030, 4'h1, 7'd1, 5'd1};
        vecs[3]  = '{8'h31, 1'b1, 9'd20, 32'h3131_3131, 4'h2, 7'd2, 5'd1};
        vecs[4]  = '{8'h32, 1'b1, 9'd20, 32'h3232_3232, 4'h4, 7'd3, 5'd1};
        vecs[5]  = '{8'h33, 1'b1, 9'd20, 32'h3333_3333, 4'h8, 7'd4, 5'd1};
        vecs[6]  = '{8'h34, 1'b1, 9'd21, 32'h3434_3434, 4'h1, 7'd5, 5'd1};
        vecs[7]  = '{8'h42, 1'b1, 9'd21, 32'h4242_4242, 4'h2, 7'd6, 5'd1};
        vecs[8]  = '{8'h08, 1'b0, 9'd0,  32'h0,         4'h0, 7'd5, 5'd1};
        vecs[9]  = '{8'h0D, 1'b0, 9'd0,  32'h0,         4'h0, 7'd0, 5'd1};
        vecs[10] = '{8'h07, 1'b0, 9'd0,  32'h0,         4'h0, 7'd0, 5'd1};
        vecs[11] = '{8'h7F, 1'b0, 9'd0,  32'h0,         4'h0, 7'd0, 5'd1};
        vecs[12] = '{8'h7E, 1'b1, 9'd20, 32'h7E7E_7E7E, 4'h1, 7'd1, 5'd1};
        vecs[13] = '{8'h20, 1'b1, 9'd20, 32'h2020_2020, 4'h2, 7'd2, 5'd1};
        vecs[14] = '{8'h1F, 1'b0, 9'd0,  32'h0,         4'h0, 7'd2, 5'd1};
        vecs[15] = '{8'h08, 1'b0, 9'd0,  32'h0,         4'h0, 7'd1, 5'd1};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        fill_sel = 2'd1;
        @(negedge clk);
        fill_sel = 2'd0;
        @(negedge clk); #1;

        // Outputs while reset is held
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wstrb", 32'(vram_wstrb), 32'd0);
        chk("rst_addr", 32'(vram_addr), 32'd0);
        chk("rst_wdata", vram_wdata, 32'd0);
        chk("rst_col", 32'(cur_col), 32'd0);
        chk("rst_row", 32'(cur_row), 32'd0);

        // Clear after reset release
        @(negedge clk);
        reset = 1'b0;
        #1;
        wait_busy(n);
        chk("reset_clear_cycles", 32'(n), 32'd500);
        chk_blank("reset_clear_words", 0, 499);
        chk("post_clear_ready", 32'(in_ready), 32'd1);
        chk("post_clear_col", 32'(cur_col), 32'd0);
        chk("post_clear_row", 32'(cur_row), 32'd0);

        // Directed single-byte vectors
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].d, s, a, w);
            if (vecs[i].wr) begin
                chk($sformatf("vec%0d_addr", i), 32'(a), 32'(vecs[i].a));
                chk($sformatf("vec%0d_wdata", i), w, vecs[i].w);
                chk($sformatf("vec%0d_wstrb", i), 32'(s), 32'(vecs[i].s));
            end else begin
                chk($sformatf("vec%0d_nowrite", i), 32'(s), 32'd0);
            end
            chk($sformatf("vec%0d_col", i), 32'(cur_col), 32'(vecs[i].col));
            chk($sformatf("vec%0d_row", i), 32'(cur_row), 32'(vecs[i].row));
        end

        // Form feed: full clear and home
        send(8'h0C, s, a, w);
        wait_busy(n);
        chk("ff_clear_cycles", 32'(n), 32'd500);
        chk_blank("ff_clear_words", 0, 499);
        chk("ff_col", 32'(cur_col), 32'd0);
        chk("ff_row", 32'(cur_row), 32'd0);

        // One full row: the last write lands in word 19, lane 3, then wraps
        for (int i = 0; i < 80; i++) send(8'h21 + 8'(i), s, a, w);
        chk("row_last_addr", 32'(a), 32'd19);
        chk("row_last_wstrb", 32'(s), 32'h8);
        chk("row_last_mem", 32'(mem[19][31:24]), 32'h70);
        chk("row_wrap_col", 32'(cur_col), 32'd0);
        chk("row_wrap_row", 32'(cur_row), 32'd1);
        send(8'h08, s, a, w);
        chk("bs_col0_nowrite", 32'(s), 32'd0);
        chk("bs_col0_col", 32'(cur_col), 32'd0);
        chk("bs_col0_row", 32'(cur_row), 32'd1);

        // Scroll from the bottom row with a known pattern and a held byte
        for (int i = 0; i < 23; i++) send(8'h0A, s, a, w);
        chk("bottom_row", 32'(cur_row), 32'd24);
        fill_sel = 2'd2;
        @(negedge clk);
        fill_sel = 2'd0;
        #1;
        in_valid = 1'b1;
        in_data  = 8'h0A;
        @(negedge clk); #1;
        chk("lf_exec_nowrite", 32'(vram_wstrb), 32'd0);
        in_data = 8'h0C;
        @(negedge clk); #1;
        n = 0;
        n_rdy = 0;
        while (busy && n < 3000) begin
            if (in_ready) n_rdy++;
            n++;
            @(negedge clk); #1;
        end
        chk("scroll_cycles", 32'(n), 32'd980);
        chk("scroll_ready_low", 32'(n_rdy), 32'd0);
        bad = 0;
        for (int i = 0; i < 480; i++) if (mem[i] !== pat(i + 20)) bad++;
        chk("scroll_copied_words", 32'(bad), 32'd0);
        chk_blank("scroll_last_row", 480, 499);
        chk("scroll_untouched", mem[500], pat(500));
        chk("scroll_col", 32'(cur_col), 32'd0);
        chk("scroll_row", 32'(cur_row), 32'd24);
        chk("held_byte_ready", 32'(in_ready), 32'd1);
        @(negedge clk); #1;
        in_valid = 1'b0;
        chk("held_ff_exec_busy", 32'(busy), 32'd0);
        @(negedge clk); #1;
        wait_busy(n);
        chk("held_ff_clear_cycles", 32'(n), 32'd500);
        chk_blank("held_ff_clear_words", 0, 499);
        chk("held_ff_col", 32'(cur_col), 32'd0);
        chk("held_ff_row", 32'(cur_row), 32'd0);

        // Reset 100 cycles into a scroll
        for (int i = 0; i < 24; i++) send(8'h0A, s, a, w);
        chk("bottom_row2", 32'(cur_row), 32'd24);
        send(8'h0A, s, a, w);
        repeat (99) @(negedge clk);
        #1;
        chk("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_wstrb_now", 32'(vram_wstrb), 32'd0);
        n_wr = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (vram_wstrb != 4'h0) n_wr++;
        end
        chk("abort_writes_in_reset", 32'(n_wr), 32'd0);
        chk("abort_col", 32'(cur_col), 32'd0);
        chk("abort_row", 32'(cur_row), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        #1;
        n_wr = 0;
        bad_wr = 0;
        exp_addr = 0;
        for (int c = 0; c < 600; c++) begin
            if (vram_wstrb != 4'h0) begin
                n_wr++;
                if (vram_wstrb != 4'hF || vram_wdata != BLANK || 32'(vram_addr) != 32'(exp_addr))
                    bad_wr++;
                exp_addr++;
            end
            @(negedge clk); #1;
        end
        chk("abort_reclear_writes", 32'(n_wr), 32'd500);
        chk("abort_reclear_bad", 32'(bad_wr), 32'd0);
        chk_blank("abort_reclear_words", 0, 499);
        chk("abort_final_ready", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
